// File: rtl/regfile_pkg.sv
// Shared defaults, types and the write-priority selector for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_XLEN     = 32;
  localparam int unsigned DEF_NREGS    = 32;
  localparam int unsigned DEF_NRD      = 2;
  localparam int unsigned DEF_NWR      = 2;
  localparam int unsigned DEF_BYPASS   = 1;
  localparam int unsigned DEF_ZERO_REG = 1;
  localparam int unsigned MAX_NWR      = 2;

  function automatic int unsigned addr_width(input int unsigned nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  typedef logic [$clog2(DEF_NREGS)-1:0] reg_addr_t;
  typedef logic [DEF_XLEN-1:0]          reg_data_t;

  localparam reg_addr_t ZERO_ADDR = '0;

  typedef struct packed {
    logic       hit;
    logic [0:0] port;
  } wsel_t;

  // Highest-index hitting port wins; used for both storage writes and bypass.
  function automatic wsel_t prio_sel(input logic [MAX_NWR-1:0] hits);
    wsel_t sel;
    sel = '0;
    for (int unsigned i = 0; i < MAX_NWR; i++) begin
      if (hits[i]) begin
        sel.hit  = 1'b1;
        sel.port = 1'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, reservation beats same-cycle write.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS    = DEF_NREGS,
  parameter int unsigned NRD      = DEF_NRD,
  parameter int unsigned AW       = addr_width(DEF_NREGS),
  parameter int unsigned BYPASS   = DEF_BYPASS,
  parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NREGS-1:0]       wr_clr_i,
  input  logic                   rsv_en_i,
  input  logic [AW-1:0]          rsv_addr_i,
  input  logic [NRD-1:0][AW-1:0] raddr_i,
  input  logic [NRD-1:0]         rd_wr_hit_i,
  output logic [NRD-1:0]         rbusy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (rsv_en_i && (rsv_addr_i == AW'(r)) &&
          !((ZERO_REG != 0) && (AW'(r) == AW'(ZERO_ADDR)))) begin
        busy_d[r] = 1'b1;
      end else if (wr_clr_i[r]) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A forwarded write means the consumer already has its data this cycle.
  always_comb begin
    rbusy_o = '0;
    for (int unsigned j = 0; j < NRD; j++) begin
      if ((BYPASS != 0) && rd_wr_hit_i[j]) begin
        rbusy_o[j] = 1'b0;
      end else begin
        rbusy_o[j] = busy_q[raddr_i[j]];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, NWR posedge writes, optional bypass.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN     = DEF_XLEN,
  parameter  int unsigned NREGS    = DEF_NREGS,
  parameter  int unsigned NRD      = DEF_NRD,
  parameter  int unsigned NWR      = DEF_NWR,
  parameter  int unsigned BYPASS   = DEF_BYPASS,
  parameter  int unsigned ZERO_REG = DEF_ZERO_REG,
  localparam int unsigned AW       = addr_width(NREGS)
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [NRD-1:0][AW-1:0]   raddr,
  output logic [NRD-1:0][XLEN-1:0] rdata,
  output logic [NRD-1:0]           rbusy,
  input  logic [NWR-1:0]           wen,
  input  logic [NWR-1:0][AW-1:0]   waddr,
  input  logic [NWR-1:0][XLEN-1:0] wdata,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr
);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];
  logic [NWR-1:0]   wen_live;
  logic [NREGS-1:0] wr_hit;
  logic [NRD-1:0]   rd_hit;

  // Gating with reset keeps the bypass path quiet while the file is held clear.
  assign wen_live = wen & {NWR{Rst_n}};

  always_comb begin
    logic [MAX_NWR-1:0] hits;
    wsel_t              sel;
    for (int unsigned r = 0; r < NREGS; r++) begin
      hits = '0;
      for (int unsigned i = 0; i < NWR; i++) begin
        hits[i] = wen_live[i] && (waddr[i] == AW'(r));
      end
      if ((ZERO_REG != 0) && (AW'(r) == AW'(ZERO_ADDR))) begin
        hits = '0;
      end
      sel       = prio_sel(hits);
      wr_hit[r] = sel.hit;
      mem_d[r]  = sel.hit ? wdata[sel.port] : mem_q[r];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        mem_q[r] <= mem_d[r];
      end
    end
  end

  always_comb begin
    logic [MAX_NWR-1:0] hits;
    wsel_t              sel;
    logic               is_zero;
    for (int unsigned j = 0; j < NRD; j++) begin
      is_zero = (ZERO_REG != 0) && (raddr[j] == AW'(ZERO_ADDR));
      hits    = '0;
      for (int unsigned i = 0; i < NWR; i++) begin
        hits[i] = wen_live[i] && (waddr[i] == raddr[j]);
      end
      if (is_zero) begin
        hits = '0;
      end
      sel       = prio_sel(hits);
      rd_hit[j] = sel.hit;
      if (is_zero) begin
        rdata[j] = '0;
      end else if ((BYPASS != 0) && sel.hit) begin
        rdata[j] = wdata[sel.port];
      end else begin
        rdata[j] = mem_q[raddr[j]];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS   (NREGS),
    .NRD     (NRD),
    .AW      (AW),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk_i      (Clk),
    .rst_ni     (Rst_n),
    .wr_clr_i   (wr_hit),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .raddr_i    (raddr),
    .rd_wr_hit_i(rd_hit),
    .rbusy_o    (rbusy)
  );

endmodule
